// File: rtl/aes_clk_pkg.sv
// Shared constants and types for the AES clock-enable generator.
// The optional jitter LFSR (macro CLK_JITTER_EN) uses LFSR_TAPS from here.
package aes_clk_pkg;

    localparam logic [1:0] DIV_1 = 2'b00;
    localparam logic [1:0] DIV_2 = 2'b01;
    localparam logic [1:0] DIV_5 = 2'b10;
    localparam logic [1:0] DIV_N = 2'b11;

    localparam int RATIO_RESET = 2;

    typedef enum logic {
        RUN_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_e;

    // Right-shift Galois toggle mask for x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/aes_jitter_lfsr.sv
// Galois LFSR that advances one step per request; exposes its low bit
// as the stretch decision for the next enable period.
module aes_jitter_lfsr
    import aes_clk_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(LFSR_TAPS)
) (
    input  logic clk,
    input  logic rst,
    input  logic step_i,
    output logic lfsr_bit_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_bit_o = lfsr_q[0];

endmodule

// File: rtl/aes_clk_en_gen.sv
// Programmable enable-strobe generator with boundary-aligned ratio updates.
// Define CLK_JITTER_EN to add LFSR-driven per-period stretch.
module aes_clk_en_gen
    import aes_clk_pkg::*;
#(
    parameter int                CNT_W     = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       div_sel,
    input  logic [CNT_W-1:0] div_n,
    input  logic             jitter_on,
    output logic             en,
    output logic             cfg_pend,
    output logic [CNT_W-1:0] cur_ratio,
    output logic             dbg_state
);

    // Handshake: a request transfers on a cycle where cfg_valid && cfg_ready;
    // the requester keeps cfg_valid and its data stable until that cycle.

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_ratio_q, cur_ratio_d;
    logic [CNT_W-1:0] pend_ratio_q, pend_ratio_d;
    logic             en_q, en_d;
    logic [CNT_W-1:0] dec_ratio;
    logic             stretch;
    logic             wrap;

    always_comb begin
        dec_ratio = CNT_W'(RATIO_RESET);
        case (div_sel)
            DIV_1:   dec_ratio = CNT_W'(1);
            DIV_2:   dec_ratio = CNT_W'(2);
            DIV_5:   dec_ratio = CNT_W'(5);
            default: dec_ratio = (div_n < CNT_W'(2)) ? CNT_W'(2) : div_n;
        endcase
    end

    // One extra bit so a stretched maximum-ratio period does not overflow.
    assign wrap = ({1'b0, cnt_q} ==
                   ({1'b0, cur_ratio_q} - (CNT_W+1)'(1) + {{CNT_W{1'b0}}, stretch}));

`ifdef CLK_JITTER_EN
    logic stretch_q, stretch_d;
    logic lfsr_bit;

    aes_jitter_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (LFSR_SEED),
        .TAPS   (LFSR_W'(LFSR_TAPS))
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .step_i     (run && wrap),
        .lfsr_bit_o (lfsr_bit)
    );

    always_comb begin
        stretch_d = stretch_q;
        if (!run) begin
            stretch_d = 1'b0;
        end else if (wrap) begin
            stretch_d = jitter_on & lfsr_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stretch_q <= 1'b0;
        end else begin
            stretch_q <= stretch_d;
        end
    end

    assign stretch = stretch_q;
`else
    logic [2:0] unused_jitter;
    assign unused_jitter = {jitter_on, ^LFSR_SEED, ^LFSR_TAPS};
    assign stretch       = 1'b0;
`endif

    always_comb begin
        cnt_d        = cnt_q;
        en_d         = 1'b0;
        state_d      = state_q;
        cur_ratio_d  = cur_ratio_q;
        pend_ratio_d = pend_ratio_q;
        cfg_ready    = 1'b0;
        cfg_pend     = 1'b0;

        if (!run) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
            en_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            RUN_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    pend_ratio_d = dec_ratio;
                    state_d      = CFG_PEND;
                end
            end
            CFG_PEND: begin
                cfg_pend = 1'b1;
                // With run low there is no period in flight, so apply at once.
                if (!run || wrap) begin
                    cur_ratio_d = pend_ratio_q;
                    state_d     = RUN_IDLE;
                end
            end
            default: state_d = RUN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN_IDLE;
            cnt_q        <= '0;
            en_q         <= 1'b0;
            cur_ratio_q  <= CNT_W'(RATIO_RESET);
            pend_ratio_q <= CNT_W'(RATIO_RESET);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            cur_ratio_q  <= cur_ratio_d;
            pend_ratio_q <= pend_ratio_d;
        end
    end

    assign en        = en_q;
    assign cur_ratio = cur_ratio_q;
    assign dbg_state = state_q;

endmodule
